// File: rtl/avalon_sdram_responder_if.sv
// Avalon-MM bus between sdram_master_0 and the SDRAM responder model,
// plus the responder's status outputs.
interface avalon_sdram_responder_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [15:0]       avs_writedata;
    logic [1:0]        avs_byteenable;
    logic              avs_waitrequest;
    logic [15:0]       avs_readdata;
    logic              avs_readdatavalid;
    logic [3:0]        pending_count;
    logic              err_rw;
    logic [15:0]       read_total;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_waitrequest, avs_readdata, avs_readdatavalid,
        output pending_count, err_rw, read_total
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid,
        input  pending_count, err_rw, read_total
    );
endinterface

// File: rtl/avalon_sdram_responder.sv
// Avalon-MM slave standing in for the 16-bit SDRAM controller: local word array,
// fixed-latency pipelined reads, pending-read limit and optional stall injection.
module avalon_sdram_responder #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 2,
    parameter int WAIT_EVERY   = 0
) (
    input  logic clk,
    input  logic reset,
    avalon_sdram_responder_if.slave avs
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int SCW   = (WAIT_EVERY > 1) ? $clog2(WAIT_EVERY) : 1;

    logic [DATA_W-1:0]       r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_vld_p;
    logic [DATA_W-1:0]       r_data_p [READ_LATENCY];
    logic [3:0]              r_pending;
    logic                    r_err_rw;
    logic [15:0]             r_read_total;
    logic                    r_stall_q;
    logic [SCW-1:0]          r_stall_cnt;

    logic              w_at_limit;
    logic              w_waitreq;
    logic              w_accept;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_rw_err;
    logic              w_rsp;
    logic [DATA_W-1:0] w_rd_word;

    // Read+write together is consumed as a protocol error: it is accepted but
    // performs neither access.
    assign w_at_limit = (r_pending == 4'(MAX_PENDING));
    assign w_waitreq  = !reset && (r_stall_q || (avs.avs_read && w_at_limit));
    assign w_accept   = !reset && (avs.avs_read || avs.avs_write) && !w_waitreq;
    assign w_rd_acc   = w_accept && avs.avs_read && !avs.avs_write;
    assign w_wr_acc   = w_accept && avs.avs_write && !avs.avs_read;
    assign w_rw_err   = w_accept && avs.avs_read && avs.avs_write;
    assign w_rsp      = r_vld_p[READ_LATENCY-1];
    assign w_rd_word  = r_mem[avs.avs_address];

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            if (avs.avs_byteenable[0]) r_mem[avs.avs_address][7:0]  <= avs.avs_writedata[7:0];
            if (avs.avs_byteenable[1]) r_mem[avs.avs_address][15:8] <= avs.avs_writedata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p      <= '0;
            r_pending    <= '0;
            r_err_rw     <= 1'b0;
            r_read_total <= '0;
            r_stall_q    <= 1'b0;
            r_stall_cnt  <= '0;
        end else begin
            r_vld_p[0] <= w_rd_acc;
            for (int i = 1; i < READ_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
            r_err_rw <= w_rw_err;
            if (w_rd_acc) r_read_total <= r_read_total + 16'd1;
            if (w_rd_acc && !w_rsp)      r_pending <= r_pending + 4'd1;
            else if (!w_rd_acc && w_rsp) r_pending <= r_pending - 4'd1;
            // Stall lasts exactly one cycle after every WAIT_EVERY-th acceptance.
            r_stall_q <= 1'b0;
            if (WAIT_EVERY > 0 && w_accept) begin
                if (r_stall_cnt == SCW'(WAIT_EVERY - 1)) begin
                    r_stall_cnt <= '0;
                    r_stall_q   <= 1'b1;
                end else begin
                    r_stall_cnt <= r_stall_cnt + 1'b1;
                end
            end
        end
    end

    // Stage p0 captures the array word in the acceptance cycle; the last stage drives readdata.
    always_ff @(posedge clk) begin
        r_data_p[0] <= w_rd_word;
        for (int i = 1; i < READ_LATENCY; i++) r_data_p[i] <= r_data_p[i-1];
        if (reset) r_data_p[READ_LATENCY-1] <= '0;
    end

    assign avs.avs_waitrequest   = w_waitreq;
    assign avs.avs_readdata      = r_data_p[READ_LATENCY-1];
    assign avs.avs_readdatavalid = w_rsp;
    assign avs.pending_count     = r_pending;
    assign avs.err_rw            = r_err_rw;
    assign avs.read_total        = r_read_total;
endmodule
